mld_7_3_decoder: RTL

MLD_7_3_DECODER -- requirements
Module: mld_7_3_decoder

---
 rtl/mld_7_3_pkg.sv | 36 +++
 rtl/mld_majority4.sv | 23 ++
 rtl/mld_7_3_decoder.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mld_7_3_pkg.sv
// Shared constants and types for the (7,3) cyclic majority-logic decoder.
//
// Contents:
//   N, K          - code length and number of info bits
//   CHK_*         - index pairs whose XOR gives an independent estimate of r6
//   state_t       - decoder FSM states
//   form_estimates- packs the four r6 estimates; bit 0 is the raw r6
package mld_7_3_pkg;

    localparam int N = 7;
    localparam int K = 3;

    // Check pairs for g(x)=1+x+x^2+x^4: each pair XORs to c6 on a clean word,
    // and no buffer position appears in more than one estimate.
    localparam int CHK_A_LO = 3;
    localparam int CHK_A_HI = 5;
    localparam int CHK_B_LO = 0;
    localparam int CHK_B_HI = 4;
    localparam int CHK_C_LO = 1;
    localparam int CHK_C_HI = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        DECODE = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [3:0] form_estimates(input logic [N-1:0] r);
        return {r[CHK_C_LO] ^ r[CHK_C_HI],
                r[CHK_B_LO] ^ r[CHK_B_HI],
                r[CHK_A_LO] ^ r[CHK_A_HI],
                r[N-1]};
    endfunction

endpackage

// File: rtl/mld_majority4.sv
// Four-input majority vote with tie / disagreement indication.
//
// Ports:
//   est      in  [3:0] estimates of one code bit; est[0] is the raw received bit
//   maj      out       majority value; on a 2-2 tie, the raw bit est[0]
//   tie      out       exactly two estimates are 1
//   disagree out       at least one estimate differs from the others
module mld_majority4 (
    input  logic [3:0] est,
    output logic       maj,
    output logic       tie,
    output logic       disagree
);

    logic [2:0] w_ones;

    assign w_ones   = {2'b00, est[0]} + {2'b00, est[1]} + {2'b00, est[2]} + {2'b00, est[3]};
    assign tie      = (w_ones == 3'd2);
    assign maj      = (w_ones > 3'd2) | (tie & est[0]);
    // Unanimous votes (0 or 4 ones) are the only case with no dissent.
    assign disagree = (w_ones != 3'd0) && (w_ones != 3'd4);

endmodule

// File: rtl/mld_7_3_decoder.sv
// Serial majority-logic decoder for the cyclic (7,3) code, g(x)=1+x+x^2+x^4.
//
// Bits arrive c6 first; after the 7th accepted bit the buffer is decoded in
// three cycles (c6, c5, c4), each followed by a left rotation, then one DONE
// cycle produces a registered one-cycle info_valid pulse.
//
// Optional feature: define MLD_ERR_STATUS_EN to build tie/disagreement
// tracking, err_corrected, err_detected and err_count. Without it those
// ports are tied to 0 and decoding/timing are identical.
//
// Ports:
//   clk           in           rising-edge clock
//   reset         in           synchronous active-high reset
//   rx_bit        in           received code bit
//   rx_valid      in           rx_bit is valid
//   rx_ready      out          decoder accepts a bit this cycle (IDLE/SHIFT)
//   info_out      out [2:0]    decoded info {c6,c5,c4}, held until next word
//   info_valid    out          one-cycle pulse qualifying info_out and flags
//   err_corrected out          single error corrected in this word
//   err_detected  out          uncorrectable error (tie) seen in this word
//   err_count     out [CNT_W]  saturating count of corrected words
module mld_7_3_decoder
    import mld_7_3_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_bit,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic [K-1:0]     info_out,
    output logic             info_valid,
    output logic             err_corrected,
    output logic             err_detected,
    output logic [CNT_W-1:0] err_count
);

    state_t         r_state;
    state_t         w_next_state;
    logic [N-1:0]   r_buf;
    logic [2:0]     r_bit_cnt;
    logic [1:0]     r_dec_cnt;
    logic [K-1:0]   r_dec;
    logic [K-1:0]   r_info;
    logic           r_info_valid;

    logic           w_accept;
    logic           w_last_bit;
    logic           w_dec_last;
    logic [3:0]     w_est;
    logic           w_maj;
    logic           w_tie;
    logic           w_dis;

    assign w_accept   = rx_valid && rx_ready;
    assign w_last_bit = (r_bit_cnt == 3'(N - 1));
    assign w_dec_last = (r_dec_cnt == 2'(K - 1));
    assign w_est      = form_estimates(r_buf);

    mld_majority4 u_majority (
        .est      (w_est),
        .maj      (w_maj),
        .tie      (w_tie),
        .disagree (w_dis)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state and handshake
    always_comb begin
        w_next_state = r_state;
        rx_ready     = 1'b0;
        unique case (r_state)
            IDLE: begin
                rx_ready = 1'b1;
                if (rx_valid) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                rx_ready = 1'b1;
                if (rx_valid && w_last_bit) begin
                    w_next_state = DECODE;
                end
            end
            DECODE: begin
                if (w_dec_last) begin
                    w_next_state = DONE;
                end
            end
            DONE: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Receive buffer, bit counter and per-cycle decode
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf     <= '0;
            r_bit_cnt <= '0;
            r_dec_cnt <= '0;
            r_dec     <= '0;
        end else begin
            case (r_state)
                IDLE, SHIFT: begin
                    r_dec_cnt <= '0;
                    if (w_accept) begin
                        // Shift left so the first bit received lands in r6.
                        r_buf     <= {r_buf[N-2:0], rx_bit};
                        r_bit_cnt <= w_last_bit ? 3'd0 : r_bit_cnt + 3'd1;
                    end
                end
                DECODE: begin
                    // Rotating left brings the next info bit into r6 while the
                    // cyclic structure keeps the same check pairs valid.
                    r_buf     <= {r_buf[N-2:0], r_buf[N-1]};
                    r_dec     <= {r_dec[K-2:0], w_maj};
                    r_dec_cnt <= r_dec_cnt + 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Registered result, loaded from DONE and held until the next word
    always_ff @(posedge clk) begin
        if (reset) begin
            r_info       <= '0;
            r_info_valid <= 1'b0;
        end else begin
            r_info_valid <= (r_state == DONE);
            if (r_state == DONE) begin
                r_info <= r_dec;
            end
        end
    end

    assign info_out   = r_info;
    assign info_valid = r_info_valid;

`ifdef MLD_ERR_STATUS_EN
    logic             r_tie_seen;
    logic             r_dis_seen;
    logic             r_err_corr;
    logic             r_err_det;
    logic [CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tie_seen <= 1'b0;
            r_dis_seen <= 1'b0;
            r_err_corr <= 1'b0;
            r_err_det  <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            r_err_corr <= 1'b0;
            r_err_det  <= 1'b0;
            case (r_state)
                DECODE: begin
                    r_tie_seen <= r_tie_seen | w_tie;
                    r_dis_seen <= r_dis_seen | w_dis;
                end
                DONE: begin
                    r_err_det  <= r_tie_seen;
                    r_err_corr <= r_dis_seen & ~r_tie_seen;
                    if (r_dis_seen && !r_tie_seen && (r_err_cnt != '1)) begin
                        r_err_cnt <= r_err_cnt + CNT_W'(1);
                    end
                    r_tie_seen <= 1'b0;
                    r_dis_seen <= 1'b0;
                end
                default: begin
                    r_tie_seen <= 1'b0;
                    r_dis_seen <= 1'b0;
                end
            endcase
        end
    end

    assign err_corrected = r_err_corr;
    assign err_detected  = r_err_det;
    assign err_count     = r_err_cnt;
`else
    logic w_unused_status;
    assign w_unused_status = w_tie | w_dis;

    assign err_corrected = 1'b0;
    assign err_detected  = 1'b0;
    assign err_count     = '0;
`endif

endmodule
